// File: rtl/gemm_pkg.sv
// Shared types for the GeMM tile controller: FSM states and loop-order encoding.
package gemm_pkg;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Busy  = 2'd1,
        Drain = 2'd2,
        Done  = 2'd3
    } controller_state_e;

    typedef enum logic {
        LoopMNK = 1'b0,
        LoopNMK = 1'b1
    } loop_order_e;

endpackage

// File: rtl/gemm_loop_counter.sv
// Index counter that wraps to zero after reaching ceiling-1; last_o flags the final index.
module gemm_loop_counter #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             clear_i,
    input  logic [Width-1:0] ceiling_i,
    output logic [Width-1:0] count_o,
    output logic             last_o
);

    assign last_o = (count_o == ceiling_i - Width'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (tick_i) begin
            count_o <= last_o ? '0 : count_o + Width'(1);
        end
    end

endmodule

// File: rtl/gemm_tile_controller.sv
// Tiled GeMM loop controller: walks M x N output tiles with a K reduction per tile.
// state | meaning
// Idle  | waiting for start_i; sizes and loop order latched on start
// Busy  | operand beats accepted, results emitted per completed tile
// Drain | last beat accepted, waiting for the final result handshake
// Done  | one-cycle completion pulse, counters cleared
module gemm_tile_controller
    import gemm_pkg::*;
#(
    parameter int AddrWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 loop_order_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic                 input_valid_i,
    output logic                 input_ready_o,
    output logic                 acc_clear_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] K_count_o,
    output logic [AddrWidth-1:0] N_count_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [AddrWidth-1:0] result_m_o,
    output logic [AddrWidth-1:0] result_n_o,
    output logic                 busy_o,
    output logic                 done_o
);

    controller_state_e    state_q, state_d;
    loop_order_e          order_q;
    logic [AddrWidth-1:0] m_size_q, k_size_q, n_size_q;

    logic fire, start_ok, zero_size, cnt_clear, result_hs;
    logic k_last, m_last, n_last, k_wrap, m_tick, n_tick, last_tile;

    assign input_ready_o = (state_q == Busy) && (!result_valid_o || result_ready_i);
    assign fire          = input_valid_i && input_ready_o;
    assign acc_clear_o   = fire && (K_count_o == '0);
    assign result_hs     = result_valid_o && result_ready_i;
    assign start_ok      = (state_q == Idle) && start_i;
    assign zero_size     = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    assign cnt_clear     = start_ok || (state_q == Done);
    assign busy_o        = (state_q != Idle);
    assign done_o        = (state_q == Done);

    // Ticks are derived from last flags rather than chained wraps so the
    // order mux never forms a structural loop between the M and N counters.
    assign k_wrap    = fire && k_last;
    assign m_tick    = (order_q == LoopNMK) ? k_wrap : (k_wrap && n_last);
    assign n_tick    = (order_q == LoopMNK) ? k_wrap : (k_wrap && m_last);
    assign last_tile = k_wrap && m_last && n_last;

    gemm_loop_counter #(.Width(AddrWidth)) u_k_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (fire),
        .clear_i  (cnt_clear),
        .ceiling_i(k_size_q),
        .count_o  (K_count_o),
        .last_o   (k_last)
    );

    gemm_loop_counter #(.Width(AddrWidth)) u_m_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (m_tick),
        .clear_i  (cnt_clear),
        .ceiling_i(m_size_q),
        .count_o  (M_count_o),
        .last_o   (m_last)
    );

    gemm_loop_counter #(.Width(AddrWidth)) u_n_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (n_tick),
        .clear_i  (cnt_clear),
        .ceiling_i(n_size_q),
        .count_o  (N_count_o),
        .last_o   (n_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Idle:    if (start_i) state_d = zero_size ? Done : Busy;
            Busy:    if (last_tile) state_d = Drain;
            Drain:   if (result_hs) state_d = Done;
            Done:    state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= Idle;
            order_q        <= LoopMNK;
            m_size_q       <= '0;
            k_size_q       <= '0;
            n_size_q       <= '0;
            result_valid_o <= 1'b0;
            result_m_o     <= '0;
            result_n_o     <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                order_q  <= loop_order_e'(loop_order_i);
                m_size_q <= M_size_i;
                k_size_q <= K_size_i;
                n_size_q <= N_size_i;
            end
            // A completion in the same cycle as a handshake reloads the slot.
            if (k_wrap) begin
                result_valid_o <= 1'b1;
                result_m_o     <= M_count_o;
                result_n_o     <= N_count_o;
            end else if (result_hs) begin
                result_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gemm_tile_controller.sv
// Randomized bench for gemm_tile_controller against a loop-nest reference model.
module tb_gemm_tile_controller;

    localparam int AW = 16;
    localparam int P_IDLE  = 0;
    localparam int P_BUSY  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    typedef struct {
        int m;
        int k;
        int n;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          loop_order_i = 1'b0;
    logic [AW-1:0] M_size_i = '0;
    logic [AW-1:0] K_size_i = '0;
    logic [AW-1:0] N_size_i = '0;
    logic          input_valid_i = 1'b0;
    logic          result_ready_i = 1'b0;
    logic          input_ready_o, acc_clear_o, result_valid_o, busy_o, done_o;
    logic [AW-1:0] M_count_o, K_count_o, N_count_o, result_m_o, result_n_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    gemm_tile_controller #(.AddrWidth(AW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .loop_order_i  (loop_order_i),
        .M_size_i      (M_size_i),
        .K_size_i      (K_size_i),
        .N_size_i      (N_size_i),
        .input_valid_i (input_valid_i),
        .input_ready_o (input_ready_o),
        .acc_clear_o   (acc_clear_o),
        .M_count_o     (M_count_o),
        .K_count_o     (K_count_o),
        .N_count_o     (N_count_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .result_m_o    (result_m_o),
        .result_n_o    (result_n_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, input_ready_o, 0);
        chk({tag, "_acc_clear"}, acc_clear_o, 0);
        chk({tag, "_rvalid"}, result_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_m_cnt"}, M_count_o, 0);
        chk({tag, "_k_cnt"}, K_count_o, 0);
        chk({tag, "_n_cnt"}, N_count_o, 0);
        chk({tag, "_res_m"}, result_m_o, 0);
        chk({tag, "_res_n"}, result_n_o, 0);
    endtask

    // Expected beat and result order comes straight from the loop nest.
    task automatic run_job(input int m, input int k, input int n, input bit order,
                           input int vprob, input int rprob, input int hold);
        beat_t beats[$];
        beat_t results[$];
        beat_t b;
        int    phase, hold_left, outer_sz, mid_sz;
        bit    exp_rv, exp_ready, fire, hs, compl, finished;

        outer_sz  = order ? n : m;
        mid_sz    = order ? m : n;
        hold_left = hold;
        if (m != 0 && k != 0 && n != 0) begin
            for (int o = 0; o < outer_sz; o++) begin
                for (int mi = 0; mi < mid_sz; mi++) begin
                    b.m = order ? mi : o;
                    b.n = order ? o : mi;
                    for (int kk = 0; kk < k; kk++) begin
                        b.k = kk;
                        beats.push_back(b);
                    end
                    b.k = 0;
                    results.push_back(b);
                end
            end
        end

        start_i        = 1'b1;
        loop_order_i   = order;
        M_size_i       = AW'(m);
        K_size_i       = AW'(k);
        N_size_i       = AW'(n);
        input_valid_i  = ($urandom_range(0, 99) < vprob);
        result_ready_i = 1'b1;
        @(negedge clk_i);
        chk("start_busy", busy_o, 0);
        chk("start_ready", input_ready_o, 0);
        chk("start_done", done_o, 0);
        chk("start_rvalid", result_valid_o, 0);
        phase    = (beats.size() == 0) ? P_DONE : P_BUSY;
        exp_rv   = 1'b0;
        finished = 1'b0;
        @(posedge clk_i);
        #1;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            start_i = (phase != P_IDLE) && ($urandom_range(0, 3) == 0);
            if (phase != P_IDLE) begin
                M_size_i     = AW'($urandom_range(0, 5));
                K_size_i     = AW'($urandom_range(0, 5));
                N_size_i     = AW'($urandom_range(0, 5));
                loop_order_i = 1'($urandom_range(0, 1));
            end
            input_valid_i = ($urandom_range(0, 99) < vprob);
            if (hold_left > 0 && exp_rv) begin
                result_ready_i = 1'b0;
                hold_left--;
            end else begin
                result_ready_i = ($urandom_range(0, 99) < rprob);
            end
            @(negedge clk_i);

            exp_ready = (phase == P_BUSY) && (!exp_rv || result_ready_i);
            fire      = input_valid_i && exp_ready;
            chk("input_ready", input_ready_o, exp_ready);
            chk("result_valid", result_valid_o, exp_rv);
            chk("busy", busy_o, phase != P_IDLE);
            chk("done", done_o, phase == P_DONE);
            if (exp_rv) begin
                chk("result_m", result_m_o, results[0].m);
                chk("result_n", result_n_o, results[0].n);
            end
            if (fire) begin
                b = beats[0];
                chk("m_count", M_count_o, b.m);
                chk("k_count", K_count_o, b.k);
                chk("n_count", N_count_o, b.n);
                chk("acc_clear", acc_clear_o, b.k == 0);
            end else begin
                chk("acc_clear_idle", acc_clear_o, 0);
            end

            if (phase == P_IDLE) begin
                chk("idle_m_cnt", M_count_o, 0);
                chk("idle_k_cnt", K_count_o, 0);
                chk("idle_n_cnt", N_count_o, 0);
                chk("results_left", results.size(), 0);
                finished = 1'b1;
            end else begin
                hs    = exp_rv && result_ready_i;
                compl = 1'b0;
                if (fire) begin
                    compl = (beats[0].k == k - 1);
                    void'(beats.pop_front());
                end
                if (hs) void'(results.pop_front());
                if (compl) exp_rv = 1'b1;
                else if (hs) exp_rv = 1'b0;
                case (phase)
                    P_BUSY:  if (fire && beats.size() == 0) phase = P_DRAIN;
                    P_DRAIN: if (hs) phase = P_DONE;
                    default: phase = P_IDLE;
                endcase
            end
            @(posedge clk_i);
            #1;
        end
        if (!finished) chk("job_timeout", 0, 1);
        start_i       = 1'b0;
        input_valid_i = 1'b0;
    endtask

    task automatic reset_midrun();
        start_i        = 1'b1;
        loop_order_i   = 1'b0;
        M_size_i       = AW'(2);
        K_size_i       = AW'(3);
        N_size_i       = AW'(2);
        input_valid_i  = 1'b1;
        result_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        chk("mid_m", M_count_o, 0);
        chk("mid_k", K_count_o, 2);
        chk("mid_n", N_count_o, 1);
        chk("mid_busy", busy_o, 1);
        #1 rst_ni = 1'b0;
        #1 chk_all_zero("abort");
        @(posedge clk_i);
        #1;
        chk("abort_no_done", done_o, 0);
        input_valid_i = 1'b0;
        rst_ni        = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        run_job(2, 3, 2, 1'b0, 100, 100, 0);
        run_job(2, 3, 2, 1'b1, 100, 100, 0);
        run_job(1, 1, 3, 1'b0, 100, 100, 5);
        run_job(2, 0, 2, 1'b0, 100, 100, 0);
        run_job(0, 2, 2, 1'b1, 100, 100, 0);
        run_job(3, 2, 0, 1'b0, 100, 100, 0);
        reset_midrun();
        run_job(2, 3, 2, 1'b0, 100, 100, 0);
        run_job(3, 1, 2, 1'b1, 100, 100, 0);
        run_job(1, 1, 1, 1'b0, 100, 100, 0);

        for (int j = 0; j < 25; j++) begin
            int mm, kk, nn;
            mm = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            kk = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            nn = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            run_job(mm, kk, nn, 1'($urandom_range(0, 1)), $urandom_range(30, 100),
                    $urandom_range(30, 100), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gemm_tile_controller.md
# gemm_tile_controller

Tiled GeMM loop controller driving the PE array datapath. It walks M×N output tiles with a K reduction inside each one. Loop order between M and N is selectable at run time, and input beats and results both use valid/ready handshakes with backpressure. Sizes are latched at start, zero sizes are handled, and each completed result is tagged with its (M, N) coordinates.

## Interface
Parameters:
- AddrWidth, 16, width of size and counter signals; sizes 0..2^AddrWidth-1 tiles
Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active-low
- start_i  in  1  start request; honoured only in Idle
- loop_order_i  in  1  0: M outer, N middle (MNK); 1: N outer, M middle (NMK); sampled with start_i
- M_size_i, K_size_i, N_size_i  in  AddrWidth  tile counts; sampled with start_i
- input_valid_i  in  1  operand beat available
- input_ready_o  out  1  controller accepts beat
- acc_clear_o  out  1  current accepted beat is first K beat of a tile (datapath overwrites accumulator)
- M_count_o, K_count_o, N_count_o  out  AddrWidth  indices of the beat presented now
- result_valid_o  out  1  completed tile result pending
- result_ready_i  in  1  downstream accepts result
- result_m_o, result_n_o  out  AddrWidth  coordinates of the pending result
- busy_o  out  1  state != Idle
- done_o  out  1  one-cycle completion pulse

## Operation
- Reset: state Idle; all counters, result_m_o/result_n_o, result_valid_o, done_o, busy_o, input_ready_o, acc_clear_o are 0.
- States:
  - Idle: on start_i, latch sizes and loop_order_i. If any size is 0, go to Done; else go to Busy.
  - Busy: beats are accepted.
  - Drain: last beat accepted; wait for the final result handshake.
  - Done: done_o=1 for exactly one cycle; clear counters; go to Idle.
- Beat accept: fire = input_valid_i && input_ready_o. input_ready_o = (state==Busy) && (!result_valid_o || result_ready_i).
- On fire, K increments. When K = K_size-1 it wraps to 0 and ticks the middle counter. When the middle counter wraps, it ticks the outer counter. MNK: middle=N, outer=M; NMK: middle=M, outer=N.
- acc_clear_o = fire && K_count_o==0.
- Tile completion is a fire with K_count_o==K_size-1. On the next edge: result_valid_o←1, result_m_o/result_n_o←indices of that beat.
- The result holds stable until result_ready_i; result_valid_o clears on handshake unless a new completion occurs in the same cycle. In that case the slot is reloaded and result_valid_o stays 1.
- The completion of the last tile (all counters at size-1) moves the state to Drain. Drain→Done on the cycle the final result handshakes.
- Counters are compared against latched sizes only; input size changes mid-run are ignored. start_i outside Idle is ignored.
- Async reset mid-run aborts immediately to the reset state; no done_o.

## Timing
- Start to first input_ready_o: 1 cycle (state Busy on the edge after start_i).
- Last K beat to result_valid_o: 1 cycle.
- Final result handshake to done_o: 1 cycle (Done state); back in Idle the cycle after.
- Zero-size start: done_o 1 cycle after start_i, no result_valid_o.
- input_ready_o has a combinational path from result_ready_i; no other input-to-output combinational paths besides acc_clear_o (from input_valid_i).
- Sustained throughput: 1 beat/cycle when result_ready_i is held high, including K_size=1 (a result every cycle).

## Structure
- gemm_pkg holds:
  - controller_state_e {Idle, Busy, Drain, Done}
  - loop_order_e {LoopMNK=0, LoopNMK=1}
- One sub-module: gemm_loop_counter, a ceiling counter with tick, clear, ceiling and a last-value flag. It is instantiated three times; the tick and ceiling sources are muxed by the latched loop order.
- Single always_ff for state, latched sizes/order and the result slot; combinational next-state/ready logic.

## Test plan
- Basic MNK run: M=2, K=3, N=2, valid always high, ready always high. Requires 12 beats, acc_clear_o on beats 0,3,6,9, and results (0,0),(0,1),(1,0),(1,1). done_o fires 1 cycle after the 4th result.
- NMK order: same sizes with loop_order_i=1. Required result order is (0,0),(1,0),(0,1),(1,1).
- Backpressure: M=1, K=1, N=3, result_ready_i low for 5 cycles after the first result. Requires input_ready_o low, the result (0,0) held stable, no beats lost, and 3 results total.
- Zero size: K=0 with start_i. Requires done_o pulse at cycle+1, no input_ready_o, no result_valid_o.
- Ignored inputs: start_i re-asserted in Busy and N_size_i changed mid-run. Count and results match the original sizes.
- Reset mid-run: assert rst_ni low during beat 5 of a 2×3×2 run. All outputs go to 0 immediately; a subsequent start runs cleanly from (0,0,0).
